// File: rtl/demux_32_bit_reg.sv
// ---------------------------------------------------------------------------
// demux_32_bit_reg
// Registered 1:2 demultiplexer. One source word is steered by `select` into
// one of two single-entry output registers, each with its own valid/ready
// handshake so the two consumers can stall independently.
//
// Optional build macro: DEMUX_32_BIT_STATS_EN
//   When defined, adds 16-bit accept counters count_0 / count_1 (wrapping).
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   in           in   source data word (WIDTH)
//   in_valid     in   source word present
//   select       in   0 -> channel 0, 1 -> channel 1
//   in_ready     out  selected channel can take a word this cycle
//   out_0        out  channel 0 data register (WIDTH)
//   out_0_valid  out  channel 0 holds an undelivered word
//   out_0_ready  in   channel 0 consumer accepts
//   out_1        out  channel 1 data register (WIDTH)
//   out_1_valid  out  channel 1 holds an undelivered word
//   out_1_ready  in   channel 1 consumer accepts
//   count_0/1    out  accept counters (DEMUX_32_BIT_STATS_EN only)
// ---------------------------------------------------------------------------
module demux_32_bit_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             select,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_0,
    output logic             out_0_valid,
    input  logic             out_0_ready,
    output logic [WIDTH-1:0] out_1,
    output logic             out_1_valid,
    input  logic             out_1_ready
`ifdef DEMUX_32_BIT_STATS_EN
    ,
    output logic [15:0]      count_0,
    output logic [15:0]      count_1
`endif
);

    logic [WIDTH-1:0] r_data_0;
    logic [WIDTH-1:0] r_data_1;
    logic             r_valid_0;
    logic             r_valid_1;

    logic w_room_0;
    logic w_room_1;
    logic w_acc_0;
    logic w_acc_1;
    logic w_dlv_0;
    logic w_dlv_1;

    // A channel has room when empty or when its word leaves on this edge,
    // which gives back-to-back throughput without a bubble.
    assign w_room_0 = !r_valid_0 || out_0_ready;
    assign w_room_1 = !r_valid_1 || out_1_ready;

    assign in_ready = select ? w_room_1 : w_room_0;

    assign w_acc_0 = in_valid && !select && w_room_0;
    assign w_acc_1 = in_valid &&  select && w_room_1;
    assign w_dlv_0 = r_valid_0 && out_0_ready;
    assign w_dlv_1 = r_valid_1 && out_1_ready;

    // Accept takes priority over deliver so a same-edge refill keeps valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_0  <= '0;
            r_valid_0 <= 1'b0;
        end else if (w_acc_0) begin
            r_data_0  <= in;
            r_valid_0 <= 1'b1;
        end else if (w_dlv_0) begin
            r_valid_0 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_1  <= '0;
            r_valid_1 <= 1'b0;
        end else if (w_acc_1) begin
            r_data_1  <= in;
            r_valid_1 <= 1'b1;
        end else if (w_dlv_1) begin
            r_valid_1 <= 1'b0;
        end
    end

    assign out_0       = r_data_0;
    assign out_1       = r_data_1;
    assign out_0_valid = r_valid_0;
    assign out_1_valid = r_valid_1;

`ifdef DEMUX_32_BIT_STATS_EN
    logic [15:0] r_count_0;
    logic [15:0] r_count_1;

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count_0 <= '0;
            r_count_1 <= '0;
        end else begin
            if (w_acc_0) r_count_0 <= r_count_0 + 16'd1;
            if (w_acc_1) r_count_1 <= r_count_1 + 16'd1;
        end
    end

    assign count_0 = r_count_0;
    assign count_1 = r_count_1;
`endif

endmodule

// File: tb/tb_demux_32_bit_reg.sv
module tb_demux_32_bit_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_d;
    logic         in_valid;
    logic         select;
    logic         in_ready;
    logic [W-1:0] out_0;
    logic         out_0_valid;
    logic         out_0_ready;
    logic [W-1:0] out_1;
    logic         out_1_valid;
    logic         out_1_ready;
`ifdef DEMUX_32_BIT_STATS_EN
    logic [15:0]  count_0;
    logic [15:0]  count_1;
`endif

    demux_32_bit_reg #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in_d),
        .in_valid    (in_valid),
        .select      (select),
        .in_ready    (in_ready),
        .out_0       (out_0),
        .out_0_valid (out_0_valid),
        .out_0_ready (out_0_ready),
        .out_1       (out_1),
        .out_1_valid (out_1_valid),
        .out_1_ready (out_1_ready)
`ifdef DEMUX_32_BIT_STATS_EN
        ,
        .count_0     (count_0),
        .count_1     (count_1)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: each channel is a one-slot buffer; the queues hold
    // words that were sent but not yet consumed, in send order.
    bit           m_full [2];
    logic [W-1:0] m_data [2];
    logic [W-1:0] q_sent0 [$];
    logic [W-1:0] q_sent1 [$];
    logic [15:0]  m_cnt  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit rdy_of(input int k);
        return (k == 0) ? out_0_ready : out_1_ready;
    endfunction

    function automatic bit room(input int k);
        return !m_full[k] || rdy_of(k);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 0;
            m_data[k] = '0;
            m_cnt[k]  = '0;
        end
        q_sent0.delete();
        q_sent1.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_v0"}, 64'(out_0_valid), 64'(m_full[0]));
        chk({tag, "_v1"}, 64'(out_1_valid), 64'(m_full[1]));
        chk({tag, "_d0"}, 64'(out_0), 64'(m_data[0]));
        chk({tag, "_d1"}, 64'(out_1), 64'(m_data[1]));
`ifdef DEMUX_32_BIT_STATS_EN
        chk({tag, "_c0"}, 64'(count_0), 64'(m_cnt[0]));
        chk({tag, "_c1"}, 64'(count_1), 64'(m_cnt[1]));
`endif
    endtask

    // Called with inputs already driven; checks in_ready and any delivered
    // word, advances one edge, then checks the registered state.
    task automatic tick(input string tag);
        bit           dlv [2];
        bit           acc;
        int           k;
        logic [W-1:0] exp_w;
        #1;
        k = select ? 1 : 0;
        chk({tag, "_rdy"}, 64'(in_ready), 64'(room(k)));
        acc = in_valid && room(k);
        for (int c = 0; c < 2; c++) dlv[c] = m_full[c] && rdy_of(c);
        if (dlv[0]) begin
            exp_w = (q_sent0.size() > 0) ? q_sent0.pop_front() : 'x;
            chk({tag, "_ord0"}, 64'(out_0), 64'(exp_w));
            m_full[0] = 0;
        end
        if (dlv[1]) begin
            exp_w = (q_sent1.size() > 0) ? q_sent1.pop_front() : 'x;
            chk({tag, "_ord1"}, 64'(out_1), 64'(exp_w));
            m_full[1] = 0;
        end
        if (acc) begin
            m_full[k] = 1;
            m_data[k] = in_d;
            m_cnt[k]  = m_cnt[k] + 16'd1;
            if (k == 0) q_sent0.push_back(in_d);
            else        q_sent1.push_back(in_d);
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
        in_valid = v;
        select   = s;
        in_d     = d;
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_clear();
        check_state(tag);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        select      = 1'b0;
        in_d        = '0;
        out_0_ready = 1'b1;
        out_1_ready = 1'b1;
        model_clear();
        @(posedge clk);
        #1;

        // 1. reset then idle
        pulse_reset("rst1");
        for (int i = 0; i < 5; i++) tick("idle");
        select = 1'b0; #1; chk("idle_rdy_s0", 64'(in_ready), 64'd1);
        select = 1'b1; #1; chk("idle_rdy_s1", 64'(in_ready), 64'd1);

        // 2. single route to channel 1
        drive(1, 1, 32'hFFFF_FFFF);
        tick("route_acc");
        chk("route_v1", 64'(out_1_valid), 64'd1);
        chk("route_v0", 64'(out_0_valid), 64'd0);
        drive(0, 1, '0);
        tick("route_dlv");
        chk("route_drained", 64'(out_1_valid), 64'd0);
        chk("route_keep", 64'(out_1), 64'hFFFF_FFFF);

        // 3. backpressure on channel 0
        out_0_ready = 1'b0;
        drive(1, 0, 32'h0000_0000);
        tick("bp_first");
        drive(1, 0, 32'h5555_5555);
        tick("bp_stall_a");
        tick("bp_stall_b");
        chk("bp_hold", 64'(out_0), 64'h0);
        select = 1'b0; #1; chk("bp_rdy_low", 64'(in_ready), 64'd0);
        out_0_ready = 1'b1;
        tick("bp_swap");
        chk("bp_loaded", 64'(out_0), 64'h5555_5555);
        chk("bp_v_held", 64'(out_0_valid), 64'd1);
        drive(0, 0, '0);
        tick("bp_drain");

        // 4. independent channels
        out_0_ready = 1'b0;
        drive(1, 0, 32'h1234_5678);
        tick("ind_c0");
        drive(1, 1, 32'hAAAA_AAAA);
        #1; chk("ind_rdy1", 64'(in_ready), 64'd1);
        tick("ind_c1");
        chk("ind_v1", 64'(out_1_valid), 64'd1);
        chk("ind_d0", 64'(out_0), 64'h1234_5678);
        out_0_ready = 1'b1;
        drive(0, 0, '0);
        tick("ind_drain");

        // 5. streaming, alternating channels
        for (int i = 0; i < 8; i++) begin
            drive(1, i[0], $urandom());
            tick("stream");
        end
        drive(0, 0, '0);
        tick("stream_end");
        chk("stream_q0", 64'(q_sent0.size()), 64'd0);
        chk("stream_q1", 64'(q_sent1.size()), 64'd0);

        // 6. reset mid-operation with both channels stalled
        pulse_reset("rst_pre6");
        out_0_ready = 1'b1;
        out_1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h100 + i);
            tick("fill0");
        end
        out_0_ready = 1'b0;
        out_1_ready = 1'b0;
        drive(1, 1, 32'hCAFE_0001);
        tick("fill1");
        drive(0, 0, '0);
        tick("stall_both");
`ifdef DEMUX_32_BIT_STATS_EN
        chk("cnt0_pre", 64'(count_0), 64'd3);
        chk("cnt1_pre", 64'(count_1), 64'd1);
`endif
        pulse_reset("rst_mid");
        chk("rst_mid_v0", 64'(out_0_valid), 64'd0);
        chk("rst_mid_d1", 64'(out_1), 64'd0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            out_0_ready = ($urandom_range(0, 9) < 7);
            out_1_ready = ($urandom_range(0, 9) < 6);
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom());
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_32_bit_reg.md
Name: demux_32_bit_reg

Overview:
- Registered 1:2 demultiplexer: the steering counterpart of the 2:1 32-bit mux.
- Routes one 32-bit source word to one of two destination channels, chosen by `select`.
- Each destination has a one-entry output register with a valid/ready handshake.
- Used where a single datapath result (ALU/memory word) fans out to two pipeline consumers that may stall independently.

Parameters:
- WIDTH, 32, data width of input and both outputs.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in  input  WIDTH  source data word.
- in_valid  input  1  source word present.
- select  input  1  destination: 0 -> channel 0, 1 -> channel 1.
- in_ready  output  1  block can accept the word on the selected channel this cycle.
- out_0  output  WIDTH  channel 0 data register.
- out_0_valid  output  1  channel 0 holds an undelivered word.
- out_0_ready  input  1  channel 0 consumer accepts.
- out_1  output  WIDTH  channel 1 data register.
- out_1_valid  output  1  channel 1 holds an undelivered word.
- out_1_ready  input  1  channel 1 consumer accepts.

Behaviour:
- Reset (rst low, asynchronous): out_0 = 0, out_1 = 0, out_0_valid = 0, out_1_valid = 0. Any buffered word is discarded. Deassertion takes effect at the next rising edge.
- in_ready is combinational:
  - select=0: in_ready = !out_0_valid || out_0_ready.
  - select=1: in_ready = !out_1_valid || out_1_ready.
  - in_ready depends only on the selected channel, never on in_valid.
- Accept: at a rising edge with in_valid && in_ready, `in` is written into out_k (k = select) and out_k_valid = 1. Latency is 1 cycle from accept to valid output.
- Deliver: at a rising edge with out_k_valid && out_k_ready, the word is consumed.
  - If no accept targets k on the same edge, out_k_valid = 0.
- Simultaneous deliver and accept on the same channel: the new word replaces the old one, out_k_valid stays 1. This gives full throughput of 1 word/cycle per channel.
- Unselected channel: no change except its own deliver.
  - Both channels may drain on the same edge.
  - Only one channel can be loaded per edge.
- Stall: while out_k_valid && !out_k_ready, out_k stays bit-stable and no accept targets k.
- Data after drain: out_k keeps its last value (it is not cleared). Consumers must qualify data with valid.
- select and in are sampled only on an accept edge. When in_valid=0, select is don't-care and no state changes.
- Ordering is guaranteed within a channel only. There is no ordering relation between channels.
- Width rule: data passes through unmodified at WIDTH bits. There is no arithmetic on the data path.

Optional Feature:
- Macro: DEMUX_32_BIT_STATS_EN.
- Defined:
  - Adds output ports count_0 and count_1, each 16 bits.
  - count_k increments by 1 on every accept to channel k.
  - Wraps 16'hFFFF -> 16'h0000.
  - Reset value is 0.
  - Counters do not change on delivers.
- Undefined: the ports and counters are absent. Handshake behaviour is identical in both builds.

Test Plan:
1. Reset then idle: assert rst=0 mid-cycle -> all outputs 0 immediately. Release, hold in_valid=0 for 5 cycles -> valid outputs stay 0, in_ready=1 for both select values.
2. Single route: in=32'hFFFFFFFF, select=1, in_valid=1 for one edge, out_1_ready=1 -> next cycle out_1=32'hFFFFFFFF with out_1_valid=1; out_0_valid stays 0. Following edge -> out_1_valid=0, out_1 still 32'hFFFFFFFF.
3. Backpressure: out_0_ready=0, send 32'h00000000 then 32'h55555555 to channel 0 -> first word held and stable, in_ready=0 for select=0. Raise out_0_ready -> 32'h55555555 is loaded on the delivery edge with valid held at 1.
4. Independent channels: stall channel 0 holding 32'h12345678, then send 32'hAAAAAAAA with select=1 -> in_ready=1, accepted, out_1_valid=1; out_0 unchanged.
5. Streaming: both readies=1, 8 consecutive words alternating select 0/1 -> each channel receives its 4 words in order, with one accept per cycle and no bubbles.
6. Reset mid-operation: both channels valid and stalled, pulse rst low -> both valids 0 and data 0 asynchronously. With DEMUX_32_BIT_STATS_EN, send 3 words to channel 0 and 1 word to channel 1 first -> count_0=3, count_1=1 before the reset and 0 after it.
